// File: rtl/rv_pkg.sv
// Shared definitions for the RV32I pipeline front end.
//   NOP_INSTR     : canonical bubble instruction (addi x0, x0, 0)
//   fetch_state_t : fetch FSM states
//     S_BOOT - dead cycle after reset release
//     S_REQ  - request driven to the instruction memory
//     S_WAIT - request accepted, waiting for the response
//     S_HOLD - response parked while decode is stalled
package rv_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
// Priority: flush > stall > load > bubble.
//   flush  : valid_d=0, instr_d=NOP, PCs held
//   stall  : every field held
//   load   : capture {instr, pc, pc_plus4}, valid_d=1
//   bubble : valid_d=0, instr_d=NOP, PCs held
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   flush, stall, load           control, see priority above
//   instr, pc, pc_plus4          data captured on load
//   instr_d, pc_d, pc_plus4_d    registered outputs
//   valid_d                      register holds a real instruction
module if_id_reg
  import rv_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     stall,
  input  logic                     load,
  input  logic [DATA_WIDTH-1:0]    instr,
  input  logic [ADDRESS_WIDTH-1:0] pc,
  input  logic [ADDRESS_WIDTH-1:0] pc_plus4,
  output logic [DATA_WIDTH-1:0]    instr_d,
  output logic [ADDRESS_WIDTH-1:0] pc_d,
  output logic [ADDRESS_WIDTH-1:0] pc_plus4_d,
  output logic                     valid_d
);

  localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(NOP_INSTR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_d    <= NOP;
      pc_d       <= '0;
      pc_plus4_d <= '0;
      valid_d    <= 1'b0;
    end else if (flush) begin
      instr_d <= NOP;
      valid_d <= 1'b0;
    end else if (stall) begin
      instr_d <= instr_d;
      valid_d <= valid_d;
    end else if (load) begin
      instr_d    <= instr;
      pc_d       <= pc;
      pc_plus4_d <= pc_plus4;
      valid_d    <= 1'b1;
    end else begin
      instr_d <= NOP;
      valid_d <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// IF stage: PC register, instruction-memory fetch FSM, hold buffer and the
// IF/ID register.
// Memory handshake: a request is accepted on a cycle where imem_req and
// imem_gnt are both high; imem_addr is only meaningful while imem_req is
// high. Exactly one request is outstanding; its response is the single
// imem_rvalid pulse that follows, at least one cycle after the grant.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   pc_next, redirect     next PC and taken-redirect from pc_selector
//   StallD, FlushD        hazard-unit control of IF/ID
//   imem_req/addr/gnt     request side of the memory handshake
//   imem_rvalid/rdata     response side of the memory handshake
//   PCF, PCPlus4F         fetch PC and its successor
//   InstrD, PCD, PCPlus4D, ValidD   IF/ID register contents
//   dbg_state             current fetch FSM state
module fetch_unit
  import rv_pkg::*;
#(
  parameter int                     ADDRESS_WIDTH = 32,
  parameter int                     DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR  = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ADDRESS_WIDTH-1:0] pc_next,
  input  logic                     redirect,
  input  logic                     StallD,
  input  logic                     FlushD,
  output logic                     imem_req,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  input  logic                     imem_gnt,
  input  logic                     imem_rvalid,
  input  logic [DATA_WIDTH-1:0]    imem_rdata,
  output logic [ADDRESS_WIDTH-1:0] PCF,
  output logic [ADDRESS_WIDTH-1:0] PCPlus4F,
  output logic [DATA_WIDTH-1:0]    InstrD,
  output logic [ADDRESS_WIDTH-1:0] PCD,
  output logic [ADDRESS_WIDTH-1:0] PCPlus4D,
  output logic                     ValidD,
  output fetch_state_t             dbg_state
);

  fetch_state_t            state_q, state_d;
  logic                    kill_q, kill_d;
  logic [ADDRESS_WIDTH-1:0] pcf_q, pcf_d;
  logic [DATA_WIDTH-1:0]   hold_q, hold_d;
  logic                    deliver;
  logic                    load_ifid;
  logic [DATA_WIDTH-1:0]   deliver_instr;

  assign PCF       = pcf_q;
  assign PCPlus4F  = pcf_q + ADDRESS_WIDTH'(4);  // wraps silently
  assign imem_req  = (state_q == S_REQ);
  assign imem_addr = pcf_q;
  assign dbg_state = state_q;
  // PCF does not move while parked, so the held PC is simply PCF.
  assign deliver_instr = (state_q == S_HOLD) ? hold_q : imem_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_BOOT;
      kill_q  <= 1'b0;
      pcf_q   <= RESET_VECTOR;
      hold_q  <= DATA_WIDTH'(NOP_INSTR);
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
      pcf_q   <= pcf_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    kill_d    = kill_q;
    pcf_d     = pcf_q;
    hold_d    = hold_q;
    deliver   = 1'b0;
    load_ifid = 1'b0;

    case (state_q)
      S_BOOT: state_d = S_REQ;
      S_REQ:  if (imem_gnt) state_d = S_WAIT;
      S_WAIT: begin
        if (imem_rvalid) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            deliver = 1'b1;
          end
        end
      end
      S_HOLD:  deliver = 1'b1;
      default: state_d = S_BOOT;
    endcase

    if (deliver) begin
      if (!StallD) begin
        load_ifid = 1'b1;
        pcf_d     = pc_next;
        state_d   = S_REQ;
      end else begin
        state_d = S_HOLD;
        if (state_q == S_WAIT) hold_d = imem_rdata;
      end
    end

    // A redirect overrides everything above. A response still owed by the
    // memory must be swallowed before a new request may go out, so we only
    // re-request immediately when nothing is outstanding after this edge.
    if (redirect) begin
      pcf_d     = pc_next;
      load_ifid = 1'b0;
      case (state_q)
        S_REQ: begin
          if (imem_gnt) begin
            state_d = S_WAIT;
            kill_d  = 1'b1;
          end else begin
            state_d = S_REQ;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            state_d = S_REQ;
            kill_d  = 1'b0;
          end else begin
            state_d = S_WAIT;
            kill_d  = 1'b1;
          end
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  if_id_reg #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .DATA_WIDTH   (DATA_WIDTH)
  ) u_if_id (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (FlushD),
    .stall     (StallD),
    .load      (load_ifid),
    .instr     (deliver_instr),
    .pc        (pcf_q),
    .pc_plus4  (PCPlus4F),
    .instr_d   (InstrD),
    .pc_d      (PCD),
    .pc_plus4_d(PCPlus4D),
    .valid_d   (ValidD)
  );

  // A response is only legal while a request is outstanding.
  rvalid_only_in_wait: assert property (
    @(posedge clk) disable iff (!rst_n) imem_rvalid |-> (state_q == S_WAIT)
  ) else $error("imem_rvalid outside S_WAIT");

endmodule
